// File: rtl/cpu_mem_arbiter.sv
// Two-master round-robin arbiter for the memory-access bus, with a per-grant watchdog.
// state | meaning: IDLE no owner, bus quiet | OWN0 CPU owns bus | OWN1 secondary master owns bus
module cpu_mem_arbiter #(
  parameter int   TIMEOUT_CYCLES = 256,
  parameter logic FIXED_PRIORITY = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_data_out,
  input  logic [3:0]  m0_data_mask,
  input  logic        m0_rd_req,
  input  logic        m0_wr_req,
  output logic [31:0] m0_data_in,
  output logic        m0_done,
  output logic        m0_timeout,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_data_out,
  input  logic [3:0]  m1_data_mask,
  input  logic        m1_rd_req,
  input  logic        m1_wr_req,
  output logic [31:0] m1_data_in,
  output logic        m1_done,
  output logic        m1_timeout,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_data_out,
  output logic [3:0]  bus_data_mask,
  output logic        bus_rd_req,
  output logic        bus_wr_req,
  input  logic [31:0] bus_data_in,
  input  logic        bus_done,
  output logic [1:0]  grant
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;

  logic [1:0]      state, state_nxt;
  logic            last_owner, last_owner_nxt;
  logic [WD_W-1:0] wdog, wdog_nxt;
  logic            own0, own1, active, done_hit, timeout_hit, req0, req1;

  assign own0 = (state == OWN0);
  assign own1 = (state == OWN1);
  assign req0 = m0_rd_req | m0_wr_req;
  assign req1 = m1_rd_req | m1_wr_req;

  // A master asserting both read and write gets a read.
  always_comb begin
    bus_addr      = '0;
    bus_data_out  = '0;
    bus_data_mask = '0;
    bus_rd_req    = 1'b0;
    bus_wr_req    = 1'b0;
    if (own0) begin
      bus_addr      = m0_addr;
      bus_data_out  = m0_data_out;
      bus_data_mask = m0_data_mask;
      bus_rd_req    = m0_rd_req;
      bus_wr_req    = m0_wr_req & ~m0_rd_req;
    end else if (own1) begin
      bus_addr      = m1_addr;
      bus_data_out  = m1_data_out;
      bus_data_mask = m1_data_mask;
      bus_rd_req    = m1_rd_req;
      bus_wr_req    = m1_wr_req & ~m1_rd_req;
    end
  end

  assign active      = bus_rd_req | bus_wr_req;
  assign done_hit    = bus_done & active;
  assign timeout_hit = active & ~bus_done & (wdog == WD_LAST);

  assign m0_data_in = own0 ? bus_data_in : '0;
  assign m1_data_in = own1 ? bus_data_in : '0;
  assign m0_done    = own0 & done_hit;
  assign m1_done    = own1 & done_hit;
  assign m0_timeout = own0 & timeout_hit;
  assign m1_timeout = own1 & timeout_hit;
  assign grant      = {own1, own0};

  always_comb begin
    state_nxt      = state;
    last_owner_nxt = last_owner;
    wdog_nxt       = wdog;
    case (state)
      IDLE: begin
        wdog_nxt = '0;
        if (req0 && req1)
          state_nxt = (FIXED_PRIORITY || last_owner) ? OWN0 : OWN1;
        else if (req0)
          state_nxt = OWN0;
        else if (req1)
          state_nxt = OWN1;
      end
      OWN0, OWN1: begin
        // Done, timeout or an abandoned request all release the bus the same way.
        if (done_hit || timeout_hit || !active) begin
          state_nxt      = IDLE;
          last_owner_nxt = own1;
          wdog_nxt       = '0;
        end else begin
          wdog_nxt = wdog + WD_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      wdog       <= '0;
    end else begin
      state      <= state_nxt;
      last_owner <= last_owner_nxt;
      wdog       <= wdog_nxt;
    end
  end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Bench for cpu_mem_arbiter: round-robin and fixed-priority instances share stimulus and are
// compared each cycle against a transaction-level reference model, plus directed scenario checks.
module tb_cpu_mem_arbiter;

  localparam int TO = 8;

  logic        clk, rst_n;
  logic [31:0] m0_addr, m0_data_out, m1_addr, m1_data_out, bus_data_in;
  logic [3:0]  m0_data_mask, m1_data_mask;
  logic        m0_rd_req, m0_wr_req, m1_rd_req, m1_wr_req, bus_done;

  logic [31:0] m0_data_in_a, m1_data_in_a, bus_addr_a, bus_data_out_a;
  logic [31:0] m0_data_in_b, m1_data_in_b, bus_addr_b, bus_data_out_b;
  logic [3:0]  bus_data_mask_a, bus_data_mask_b;
  logic        m0_done_a, m0_timeout_a, m1_done_a, m1_timeout_a, bus_rd_req_a, bus_wr_req_a;
  logic        m0_done_b, m0_timeout_b, m1_done_b, m1_timeout_b, bus_rd_req_b, bus_wr_req_b;
  logic [1:0]  grant_a, grant_b;
  logic [139:0] out_a, out_b;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference state: owner -1 means idle.
  int own[2];
  int last[2];
  int cnt[2];
  int fp[2];

  cpu_mem_arbiter #(.TIMEOUT_CYCLES(TO), .FIXED_PRIORITY(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .m0_addr(m0_addr), .m0_data_out(m0_data_out), .m0_data_mask(m0_data_mask),
    .m0_rd_req(m0_rd_req), .m0_wr_req(m0_wr_req),
    .m0_data_in(m0_data_in_a), .m0_done(m0_done_a), .m0_timeout(m0_timeout_a),
    .m1_addr(m1_addr), .m1_data_out(m1_data_out), .m1_data_mask(m1_data_mask),
    .m1_rd_req(m1_rd_req), .m1_wr_req(m1_wr_req),
    .m1_data_in(m1_data_in_a), .m1_done(m1_done_a), .m1_timeout(m1_timeout_a),
    .bus_addr(bus_addr_a), .bus_data_out(bus_data_out_a), .bus_data_mask(bus_data_mask_a),
    .bus_rd_req(bus_rd_req_a), .bus_wr_req(bus_wr_req_a),
    .bus_data_in(bus_data_in), .bus_done(bus_done), .grant(grant_a)
  );

  cpu_mem_arbiter #(.TIMEOUT_CYCLES(TO), .FIXED_PRIORITY(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .m0_addr(m0_addr), .m0_data_out(m0_data_out), .m0_data_mask(m0_data_mask),
    .m0_rd_req(m0_rd_req), .m0_wr_req(m0_wr_req),
    .m0_data_in(m0_data_in_b), .m0_done(m0_done_b), .m0_timeout(m0_timeout_b),
    .m1_addr(m1_addr), .m1_data_out(m1_data_out), .m1_data_mask(m1_data_mask),
    .m1_rd_req(m1_rd_req), .m1_wr_req(m1_wr_req),
    .m1_data_in(m1_data_in_b), .m1_done(m1_done_b), .m1_timeout(m1_timeout_b),
    .bus_addr(bus_addr_b), .bus_data_out(bus_data_out_b), .bus_data_mask(bus_data_mask_b),
    .bus_rd_req(bus_rd_req_b), .bus_wr_req(bus_wr_req_b),
    .bus_data_in(bus_data_in), .bus_done(bus_done), .grant(grant_b)
  );

  assign out_a = {m0_data_in_a, m0_done_a, m0_timeout_a, m1_data_in_a, m1_done_a, m1_timeout_a,
                  bus_addr_a, bus_data_out_a, bus_data_mask_a, bus_rd_req_a, bus_wr_req_a, grant_a};
  assign out_b = {m0_data_in_b, m0_done_b, m0_timeout_b, m1_data_in_b, m1_done_b, m1_timeout_b,
                  bus_addr_b, bus_data_out_b, bus_data_mask_b, bus_rd_req_b, bus_wr_req_b, grant_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [139:0] model_eval(int i);
    logic [31:0] di0, di1, ba, bd;
    logic [3:0]  bm;
    logic        rd, wr, d0, d1, t0, t1, act, dn, tmo;
    logic [1:0]  g;
    di0 = '0; di1 = '0; ba = '0; bd = '0; bm = '0;
    rd = 0; wr = 0; d0 = 0; d1 = 0; t0 = 0; t1 = 0; g = '0;
    if (rst_n && own[i] >= 0) begin
      ba  = (own[i] == 0) ? m0_addr : m1_addr;
      bd  = (own[i] == 0) ? m0_data_out : m1_data_out;
      bm  = (own[i] == 0) ? m0_data_mask : m1_data_mask;
      rd  = (own[i] == 0) ? m0_rd_req : m1_rd_req;
      wr  = ((own[i] == 0) ? m0_wr_req : m1_wr_req) & ~rd;
      act = rd | wr;
      dn  = bus_done & act;
      tmo = act & ~bus_done & (cnt[i] == TO - 1);
      if (own[i] == 0) begin
        di0 = bus_data_in; d0 = dn; t0 = tmo; g = 2'b01;
      end else begin
        di1 = bus_data_in; d1 = dn; t1 = tmo; g = 2'b10;
      end
    end
    return {di0, d0, t0, di1, d1, t1, ba, bd, bm, rd, wr, g};
  endfunction

  function automatic void model_tick(int i);
    logic r0, r1, act;
    r0 = m0_rd_req | m0_wr_req;
    r1 = m1_rd_req | m1_wr_req;
    if (!rst_n) begin
      own[i] = -1; last[i] = 1; cnt[i] = 0;
    end else if (own[i] < 0) begin
      cnt[i] = 0;
      if (r0 && r1)      own[i] = (fp[i] != 0 || last[i] == 1) ? 0 : 1;
      else if (r0)       own[i] = 0;
      else if (r1)       own[i] = 1;
    end else begin
      act = (own[i] == 0) ? r0 : r1;
      if (!act || bus_done || cnt[i] == TO - 1) begin
        last[i] = own[i]; own[i] = -1; cnt[i] = 0;
      end else begin
        cnt[i] = cnt[i] + 1;
      end
    end
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, obs, exp);
    end
  endtask

  // Settle, compare both instances against the model, advance the model, move to next negedge.
  task automatic cycle();
    logic [139:0] exp, obs;
    #1;
    for (int i = 0; i < 2; i++) begin
      exp = model_eval(i);
      obs = (i == 0) ? out_a : out_b;
      tests++;
      assert (obs === exp) else begin
        fails++;
        $error("FAIL model_dut%0d cyc=%0d got=%h exp=%h", i, cyc, obs, exp);
      end
    end
    for (int i = 0; i < 2; i++) void'(model_tick(i));
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    logic [1:0] exp_g [8];
    exp_g[0] = 2'b00; exp_g[1] = 2'b01; exp_g[2] = 2'b00; exp_g[3] = 2'b10;
    exp_g[4] = 2'b00; exp_g[5] = 2'b01; exp_g[6] = 2'b00; exp_g[7] = 2'b10;
    fp[0] = 0; fp[1] = 1;
    for (int i = 0; i < 2; i++) begin own[i] = -1; last[i] = 1; cnt[i] = 0; end
    rst_n = 0;
    m0_addr = '0; m0_data_out = '0; m0_data_mask = '0; m0_rd_req = 0; m0_wr_req = 0;
    m1_addr = '0; m1_data_out = '0; m1_data_mask = '0; m1_rd_req = 0; m1_wr_req = 0;
    bus_data_in = '0; bus_done = 0;
    @(negedge clk);
    #1 chk("reset_grant", 32'(grant_a), 32'h0);
    cycle();

    // Single CPU read, done on third granted cycle.
    rst_n = 1; m0_addr = 32'h4000_0000; m0_rd_req = 1;
    #1 chk("s1_latency", 32'(bus_rd_req_a), 32'h0);
    cycle();
    #1 chk("s1_grant", 32'(grant_a), 32'h1);
    cycle();
    cycle();
    bus_done = 1; bus_data_in = 32'hDEAD_BEEF;
    #1 chk("s1_done", 32'(m0_done_a), 32'h1);
    chk("s1_data", m0_data_in_a, 32'hDEAD_BEEF);
    cycle();
    m0_rd_req = 0; bus_done = 0;
    #1 chk("s1_idle", 32'(grant_a), 32'h0);
    cycle();

    // Simultaneous requests after reset: CPU first, then the write.
    rst_n = 0; cycle(); rst_n = 1;
    m0_rd_req = 1; m0_addr = 32'h0000_0200;
    m1_wr_req = 1; m1_addr = 32'h0000_0100; m1_data_out = 32'h1234_5678; m1_data_mask = 4'b0011;
    cycle();
    #1 chk("s2_wr_wait", 32'(bus_wr_req_a), 32'h0);
    cycle();
    bus_done = 1; cycle();
    bus_done = 0; m0_rd_req = 0; cycle();
    #1 chk("s2_mask", 32'(bus_data_mask_a), 32'h3);
    chk("s2_wr", 32'(bus_wr_req_a), 32'h1);
    bus_done = 1; cycle();
    bus_done = 0; m1_wr_req = 0; cycle();

    // Continuous requests: alternation vs fixed priority.
    m0_rd_req = 1; m1_rd_req = 1; bus_done = 1;
    for (int k = 0; k < 8; k++) begin
      #1 chk("s3_rr_grant", 32'(grant_a), 32'(exp_g[k]));
      chk("s3_fixed_no_m1", 32'(grant_b[1]), 32'h0);
      cycle();
    end
    m0_rd_req = 0; m1_rd_req = 0; bus_done = 0; cycle();

    // Watchdog: timeout on the last granted cycle, and done on that cycle wins.
    m1_rd_req = 1; cycle();
    for (int k = 1; k <= TO; k++) begin
      #1 chk("s4_timeout", 32'(m1_timeout_a), (k == TO) ? 32'h1 : 32'h0);
      chk("s4_nodone", 32'(m1_done_a), 32'h0);
      cycle();
    end
    #1 chk("s4_rd_low", 32'(bus_rd_req_a), 32'h0);
    m1_rd_req = 0; cycle();
    m1_rd_req = 1; cycle();
    for (int k = 1; k <= TO; k++) begin
      bus_done = (k == TO);
      #1 chk("s4_done_wins", 32'({m1_done_a, m1_timeout_a}), (k == TO) ? 32'h2 : 32'h0);
      cycle();
    end
    m1_rd_req = 0; bus_done = 0; cycle();

    // Reset mid-transfer, then CPU regains the bus first.
    m0_rd_req = 1; cycle(); cycle();
    rst_n = 0;
    #1 chk("s5_rst_grant", 32'(grant_a), 32'h0);
    chk("s5_rst_rd", 32'(bus_rd_req_a), 32'h0);
    cycle();
    rst_n = 1; m1_rd_req = 1; cycle();
    #1 chk("s5_regrant", 32'(grant_a), 32'h1);
    cycle();
    m0_rd_req = 0; m1_rd_req = 0; cycle(); cycle();

    // Read+write together, then abort.
    m0_rd_req = 1; m0_wr_req = 1; cycle();
    #1 chk("s6_rd_wins", 32'({bus_rd_req_a, bus_wr_req_a}), 32'h2);
    cycle(); cycle();
    m0_rd_req = 0; m0_wr_req = 0;
    #1 chk("s6_abort_nodone", 32'({m0_done_a, m0_timeout_a}), 32'h0);
    cycle();
    #1 chk("s6_idle", 32'(grant_a), 32'h0);
    cycle();

    // Random traffic including aborts, timeouts and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(7) == 0) m0_rd_req = ~m0_rd_req;
      if ($urandom_range(7) == 0) m0_wr_req = ~m0_wr_req;
      if ($urandom_range(7) == 0) m1_rd_req = ~m1_rd_req;
      if ($urandom_range(7) == 0) m1_wr_req = ~m1_wr_req;
      m0_addr = $urandom; m0_data_out = $urandom; m0_data_mask = 4'($urandom);
      m1_addr = $urandom; m1_data_out = $urandom; m1_data_mask = 4'($urandom);
      bus_data_in = $urandom;
      bus_done = ($urandom_range(3) == 0);
      rst_n = ($urandom_range(199) != 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
